// File: rtl/band_frame_sched_if.sv
// Purpose: signal bundle between the band frame scheduler, its band averager and the downstream sink.
// Latency: none (wires only).
// Backpressure: out_valid/out_ready handshake on the serialized band stream; averager side has none.
// Ports: start, mag_valid_in, avg_valid_in, avg_in, out_ready flow into the scheduler;
//        index_out, out_data, out_band, out_valid, busy, frame_done, band_miss, overrun flow out of it.
// Modports: slave = scheduler view, master = environment view.
interface band_frame_sched_if #(
  parameter int DATASIZE   = 32,
  parameter int SAMPLE_NUM = 512
);
  localparam int IW = $clog2(SAMPLE_NUM);

  logic                  start;
  logic                  mag_valid_in;
  logic [IW-1:0]         index_out;
  logic [7:0]            avg_valid_in;
  logic [8*DATASIZE-1:0] avg_in;
  logic [DATASIZE-1:0]   out_data;
  logic [2:0]            out_band;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  frame_done;
  logic [7:0]            band_miss;
  logic                  overrun;

  modport slave (
    input  start, mag_valid_in, avg_valid_in, avg_in, out_ready,
    output index_out, out_data, out_band, out_valid, busy, frame_done, band_miss, overrun
  );

  modport master (
    output start, mag_valid_in, avg_valid_in, avg_in, out_ready,
    input  index_out, out_data, out_band, out_valid, busy, frame_done, band_miss, overrun
  );
endinterface

// File: rtl/band_frame_sched.sv
// Purpose: steps the averager sample index over one frame, banks the 8 band averages, then serializes them.
// Latency: start -> busy/index_out=0 one cycle later; last sample beat -> band 0 presented one cycle later.
// Backpressure: out_ready low holds out_data/out_band/out_valid; the averager side is never stalled.
// Ports: clk, rst (sync, active-high) plus bus (band_frame_sched_if.slave) carrying the averager
//        index/valid/average signals, the out_* stream and the busy/frame_done/band_miss/overrun status.
module band_frame_sched #(
  parameter int DATASIZE   = 32,
  parameter int SAMPLE_NUM = 512,
  parameter int BANDS      = 8
) (
  input logic               clk,
  input logic               rst,
  band_frame_sched_if.slave bus
);
  localparam int            IW        = $clog2(SAMPLE_NUM);
  localparam logic [IW-1:0] IDX_LAST  = IW'(SAMPLE_NUM - 1);
  localparam logic [IW-1:0] IDX_PEN   = IW'(SAMPLE_NUM - 2);
  localparam logic [2:0]    BAND_LAST = 3'(BANDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                             state_q, state_d;
  logic [IW-1:0]                      index_q, index_d;
  logic [BANDS-1:0]                   captured_q, captured_d;
  logic [BANDS-1:0][DATASIZE-1:0]     bank_q, bank_d;
  logic [DATASIZE-1:0]                out_data_q, out_data_d;
  logic [2:0]                         out_band_q, out_band_d;
  logic                               out_valid_q, out_valid_d;
  logic                               busy_q, busy_d;
  logic                               frame_done_q, frame_done_d;
  logic [BANDS-1:0]                   band_miss_q, band_miss_d;
  logic                               overrun_q, overrun_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      index_q      <= IDX_LAST;
      captured_q   <= '0;
      bank_q       <= '0;
      out_data_q   <= '0;
      out_band_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      band_miss_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      captured_q   <= captured_d;
      bank_q       <= bank_d;
      out_data_q   <= out_data_d;
      out_band_q   <= out_band_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      band_miss_q  <= band_miss_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (bus.mag_valid_in && index_q == IDX_PEN) state_d = DRAIN;
      DRAIN:   if (bus.out_ready && out_band_q == BAND_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    index_d      = index_q;
    captured_d   = captured_q;
    bank_d       = bank_q;
    out_data_d   = out_data_q;
    out_band_d   = out_band_q;
    out_valid_d  = out_valid_q;
    frame_done_d = 1'b0;
    band_miss_d  = band_miss_q;
    overrun_d    = overrun_q;

    case (state_q)
      IDLE: begin
        // Parking the index at the last sample keeps the averager cleared.
        index_d     = IDX_LAST;
        out_valid_d = 1'b0;
        if (bus.start) begin
          index_d     = '0;
          captured_d  = '0;
          bank_d      = '0;
          band_miss_d = '0;
          overrun_d   = 1'b0;
        end
      end

      RUN: begin
        if (bus.start) overrun_d = 1'b1;
        // First valid average per band wins; later pulses for that band are dropped.
        for (int i = 0; i < BANDS; i++) begin
          if (bus.avg_valid_in[i] && !captured_q[i]) begin
            bank_d[i]     = bus.avg_in[i*DATASIZE +: DATASIZE];
            captured_d[i] = 1'b1;
          end
        end
        if (bus.mag_valid_in) begin
          if (index_q == IDX_PEN) begin
            // Final beat: captures made this same cycle still count and band 0 goes out next.
            index_d     = IDX_LAST;
            band_miss_d = ~captured_d;
            out_valid_d = 1'b1;
            out_band_d  = '0;
            out_data_d  = bank_d[0];
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end

      DRAIN: begin
        if (bus.start) overrun_d = 1'b1;
        if (bus.out_ready) begin
          if (out_band_q == BAND_LAST) begin
            out_valid_d  = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            out_band_d = out_band_q + 3'd1;
            out_data_d = bank_q[out_band_q + 3'd1];
          end
        end
      end

      default: begin
        index_d     = IDX_LAST;
        out_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.index_out  = index_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_band   = out_band_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.band_miss  = band_miss_q;
  assign bus.overrun    = overrun_q;
endmodule
